decimal_adder: RTL and testbench

Registered BCD (8421) decimal adder. It adds two packed BCD operands of DIGITS decimal digits plus a carry-in, and produces a BCD sum and a decimal carry-out. Results appear one clock after the input is sampled. It serves as the decimal-arithmetic leaf used by datapath blocks and is exercised stand-alone with single-digit operands (DIGITS=1, e.g. 5+3).

---
 rtl/decimal_adder.sv | 108 ++++++++++
 tb/tb_decimal_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_adder.sv
// ----------------------------------------------------------------------------
// decimal_adder
// Registered BCD (8421) decimal adder. Adds two packed BCD operands of DIGITS
// decimal digits plus a carry-in and presents the BCD sum, the decimal
// carry-out and an invalid-digit flag one clock after the operands are
// accepted.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, clears every output
//   A, B      - packed BCD operands, digit 0 in bits [3:0]
//   Cin       - decimal carry-in into digit 0
//   in_valid  - A, B and Cin are accepted on an edge where this is high
//   Sum       - registered BCD sum, packed like A
//   Carry     - registered decimal carry-out of the most significant digit
//   out_valid - one-cycle strobe per accepted operation
//   err       - registered flag, some nibble of A or B was above 9
// ----------------------------------------------------------------------------
module decimal_adder #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Carry,
    output logic                  out_valid,
    output logic                  err
);

    logic [4*DIGITS-1:0] sum_d;
    logic [4*DIGITS-1:0] sum_q;
    logic                carry_d;
    logic                carry_q;
    logic                err_d;
    logic                err_q;
    logic                outValid_q;

    logic [3:0]          digitA;
    logic [3:0]          digitB;
    logic [4:0]          digitSum;
    logic [4:0]          digitAdj;
    logic                rippleCarry;

    // Digit-serial ripple within one cycle. A binary digit sum above 9 is
    // pushed back into BCD range by adding 6, which also drops the decimal
    // carry out of the nibble. Any nibble outside 0..9 invalidates the whole
    // result, so the arithmetic outputs are forced to zero in that case.
    always_comb begin
        sum_d       = '0;
        carry_d     = 1'b0;
        err_d       = 1'b0;
        digitA      = 4'd0;
        digitB      = 4'd0;
        digitSum    = 5'd0;
        digitAdj    = 5'd0;
        rippleCarry = Cin;
        for (int i = 0; i < DIGITS; i++) begin
            digitA   = A[4*i +: 4];
            digitB   = B[4*i +: 4];
            if ((digitA > 4'd9) || (digitB > 4'd9)) begin
                err_d = 1'b1;
            end
            digitSum = {1'b0, digitA} + {1'b0, digitB} + {4'd0, rippleCarry};
            if (digitSum > 5'd9) begin
                digitAdj    = digitSum + 5'd6;
                rippleCarry = 1'b1;
            end else begin
                digitAdj    = digitSum;
                rippleCarry = 1'b0;
            end
            sum_d[4*i +: 4] = digitAdj[3:0];
        end
        carry_d = rippleCarry;
        if (err_d) begin
            sum_d   = '0;
            carry_d = 1'b0;
        end
    end

    // Result registers. Reset wins over an accepted operation, discarding it.
    // When no operation is accepted the strobe drops but the last result is
    // kept on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                err_q   <= err_d;
            end
        end
    end

    assign Sum       = sum_q;
    assign Carry     = carry_q;
    assign err       = err_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_decimal_adder.sv
// ----------------------------------------------------------------------------
// tb_decimal_adder
// Scoreboard bench for decimal_adder. A single-digit and a four-digit
// instance share clock and reset. Stimulus pushes hand-computed expected
// results into per-instance queues; monitors pop and compare whenever an
// instance raises out_valid.
// ----------------------------------------------------------------------------
module tb_decimal_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        cin1;
    logic        inValid1;
    logic [3:0]  sum1;
    logic        carry1;
    logic        outValid1;
    logic        err1;

    logic [15:0] a4;
    logic [15:0] b4;
    logic        cin4;
    logic        inValid4;
    logic [15:0] sum4;
    logic        carry4;
    logic        outValid4;
    logic        err4;

    exp_t        q1[$];
    exp_t        q4[$];

    int          nVectors    = 0;
    int          nMiscompares = 0;

    decimal_adder #(.DIGITS(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .A         (a1),
        .B         (b1),
        .Cin       (cin1),
        .in_valid  (inValid1),
        .Sum       (sum1),
        .Carry     (carry1),
        .out_valid (outValid1),
        .err       (err1)
    );

    decimal_adder #(.DIGITS(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .A         (a4),
        .B         (b4),
        .Cin       (cin4),
        .in_valid  (inValid4),
        .Sum       (sum4),
        .Carry     (carry4),
        .out_valid (outValid4),
        .err       (err4)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports miscompares.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one single-digit operation and record its expected result.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic cin, input logic [3:0] expSum,
                                 input logic expCarry, input logic expErr);
        exp_t e;
        a1       = a;
        b1       = b;
        cin1     = cin;
        inValid1 = 1'b1;
        e.sum    = {12'd0, expSum};
        e.carry  = expCarry;
        e.err    = expErr;
        q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue one four-digit operation and record its expected result.
    task automatic applyStimulus4(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic [15:0] expSum,
                                  input logic expCarry, input logic expErr);
        exp_t e;
        a4       = a;
        b4       = b;
        cin4     = cin;
        inValid4 = 1'b1;
        e.sum    = expSum;
        e.carry  = expCarry;
        e.err    = expErr;
        q4.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the single-digit instance, sampling on the falling edge.
    always @(negedge clk) begin
        if (outValid1) begin
            if (q1.size() == 0) begin
                checkOutput("d1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                checkOutput("d1_sum",   {28'd0, sum1},   {16'd0, e.sum});
                checkOutput("d1_carry", {31'd0, carry1}, {31'd0, e.carry});
                checkOutput("d1_err",   {31'd0, err1},   {31'd0, e.err});
            end
        end
    end

    // Monitor for the four-digit instance, sampling on the falling edge.
    always @(negedge clk) begin
        if (outValid4) begin
            if (q4.size() == 0) begin
                checkOutput("d4_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                checkOutput("d4_sum",   {16'd0, sum4},   {16'd0, e.sum});
                checkOutput("d4_carry", {31'd0, carry4}, {31'd0, e.carry});
                checkOutput("d4_err",   {31'd0, err4},   {31'd0, e.err});
            end
        end
    end

    initial begin
        int waitCycles;
        rst      = 1'b1;
        a1       = 4'h5;
        b1       = 4'h3;
        cin1     = 1'b0;
        inValid1 = 1'b1;
        a4       = 16'h0000;
        b4       = 16'h0000;
        cin4     = 1'b0;
        inValid4 = 1'b0;

        // Reset held two cycles with a valid operation pending.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_sum",       {28'd0, sum1},      32'd0);
            checkOutput("rst_carry",     {31'd0, carry1},    32'd0);
            checkOutput("rst_out_valid", {31'd0, outValid1}, 32'd0);
            checkOutput("rst_err",       {31'd0, err1},      32'd0);
        end
        rst = 1'b0;

        // 5+3, then an idle cycle: strobe drops, sum holds.
        applyStimulus(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b0);
        inValid1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_out_valid", {31'd0, outValid1}, 32'd0);
        checkOutput("idle_sum_hold",  {28'd0, sum1},      32'd8);

        // Back-to-back carry boundaries.
        applyStimulus(4'h5, 4'h5, 1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'h9, 4'h9, 1'b0, 4'h8, 1'b1, 1'b0);
        applyStimulus(4'h9, 4'h9, 1'b1, 4'h9, 1'b1, 1'b0);
        applyStimulus(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0);

        // Invalid digit, then recovery.
        applyStimulus(4'hA, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0);
        applyStimulus(4'h3, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1);
        inValid1 = 1'b0;
        @(posedge clk);
        #1;

        // A previous result is on the outputs; 7+8 offered on the same edge
        // as reset must be discarded and the outputs cleared.
        applyStimulus(4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b0);
        a1       = 4'h7;
        b1       = 4'h8;
        cin1     = 1'b0;
        inValid1 = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        inValid1 = 1'b0;
        checkOutput("midrst_out_valid", {31'd0, outValid1}, 32'd0);
        checkOutput("midrst_sum",       {28'd0, sum1},      32'd0);
        checkOutput("midrst_carry",     {31'd0, carry1},    32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_no_late_valid", {31'd0, outValid1}, 32'd0);
        applyStimulus(4'h7, 4'h8, 1'b0, 4'h5, 1'b1, 1'b0);
        inValid1 = 1'b0;

        // Four-digit ripple cases.
        applyStimulus4(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus4(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        applyStimulus4(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        applyStimulus4(16'h0500, 16'h0499, 1'b1, 16'h1000, 1'b0, 1'b0);
        applyStimulus4(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        inValid4 = 1'b0;

        // Drain both scoreboards with a bounded wait.
        waitCycles = 0;
        while (((q1.size() != 0) || (q4.size() != 0)) && (waitCycles < 20)) begin
            @(posedge clk);
            waitCycles++;
        end
        @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", q1.size() + q4.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
